// File: rtl/mips_bus_sequencer.sv
// Multi-cycle MIPS bus sequencer: orders fetch, execute, memory access and
// HI/LO wait phases, and counts retired instructions.
module mips_bus_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        md_start,
  input  logic        md_done,
  input  logic        halt_req,
  output logic [2:0]  state,
  output logic        read,
  output logic        write,
  output logic        addr_sel,
  output logic        ir_load,
  output logic        pc_write,
  output logic        reg_commit,
  output logic        active,
  output logic [31:0] instr_count
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned COUNT_W = 32;

  localparam logic [STATE_W-1:0] FETCH  = STATE_W'(0);
  localparam logic [STATE_W-1:0] EXEC1  = STATE_W'(1);
  localparam logic [STATE_W-1:0] EXEC2  = STATE_W'(2);
  localparam logic [STATE_W-1:0] MDWAIT = STATE_W'(3);
  localparam logic [STATE_W-1:0] HALTED = STATE_W'(4);

  logic [STATE_W-1:0] next_state;
  logic               mem_op;

  assign mem_op = mem_read | mem_write;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  // Retired-instruction counter; wraps naturally at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              instr_count <= '0;
    else if (state == EXEC2) instr_count <= instr_count + COUNT_W'(1);
  end

  // Next-state logic; unused codes recover to FETCH
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = waitrequest ? FETCH : EXEC1;
      EXEC1: begin
        if (mem_op)        next_state = waitrequest ? EXEC1 : EXEC2;
        else if (md_start) next_state = MDWAIT;
        else               next_state = EXEC2;
      end
      MDWAIT:  next_state = md_done ? EXEC2 : MDWAIT;
      EXEC2:   next_state = halt_req ? HALTED : FETCH;
      HALTED:  next_state = HALTED;
      default: next_state = FETCH;
    endcase
  end

  // Output decode; ir_load is gated so a held reset never captures IR
  always_comb begin
    read       = 1'b0;
    write      = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    reg_commit = 1'b0;
    active     = (state != HALTED);
    case (state)
      FETCH: begin
        read    = 1'b1;
        ir_load = reset & ~waitrequest;
      end
      EXEC1: begin
        if (mem_write) begin
          write    = 1'b1;
          addr_sel = 1'b1;
        end else if (mem_read) begin
          read     = 1'b1;
          addr_sel = 1'b1;
        end
      end
      EXEC2: begin
        pc_write   = 1'b1;
        reg_commit = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_bus_sequencer.sv
// Self-checking bench: instruction-level reference model expands each planned
// instruction into its expected per-cycle bus behaviour.
module tb_mips_bus_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        waitrequest, mem_read, mem_write, md_start, md_done, halt_req;
  logic [2:0]  state;
  logic        read, write, addr_sel, ir_load, pc_write, reg_commit, active;
  logic [31:0] instr_count;

  int total = 0;
  int bad   = 0;
  int unsigned model_count = 0;

  mips_bus_sequencer dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest),
    .mem_read(mem_read), .mem_write(mem_write), .md_start(md_start),
    .md_done(md_done), .halt_req(halt_req), .state(state),
    .read(read), .write(write), .addr_sel(addr_sel), .ir_load(ir_load),
    .pc_write(pc_write), .reg_commit(reg_commit), .active(active),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Expected observable behaviour of one cycle plus the inputs to present
  typedef struct packed {
    logic [2:0] st;
    logic rd, wr, as, il, pw, rc;
    logic wreq, mdd;
  } cyc_t;

  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BOTH = 3, K_DIV = 4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered just after a falling edge; returns just after a falling edge
  task automatic run_instr(input int kind, input int wf, input int we, input int md,
                           input logic extra_md, input logic halt);
    cyc_t q[$];
    logic is_mem, is_wr;
    is_mem = (kind == K_LW) || (kind == K_SW) || (kind == K_BOTH);
    is_wr  = (kind == K_SW) || (kind == K_BOTH);
    for (int i = 0; i < wf; i++) q.push_back({3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    q.push_back({3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    if (is_mem) begin
      for (int i = 0; i < we; i++) q.push_back({3'd1, !is_wr, is_wr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      q.push_back({3'd1, !is_wr, is_wr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    end else begin
      q.push_back({3'd1, 6'b0, 1'($urandom), 1'b0});
      if (kind == K_DIV)
        for (int i = 1; i <= md; i++) q.push_back({3'd3, 6'b0, 1'($urandom), (i == md)});
    end
    q.push_back({3'd2, 4'b0, 1'b1, 1'b1, 1'($urandom), 1'b0});
    foreach (q[i]) begin
      waitrequest = q[i].wreq;
      md_done     = q[i].mdd;
      mem_read    = (kind == K_LW) || (kind == K_BOTH);
      mem_write   = is_wr;
      md_start    = (kind == K_DIV) || (is_mem && extra_md);
      halt_req    = halt;
      #1;
      chk("outputs", {23'b0, state, read, write, addr_sel, ir_load, pc_write, reg_commit, active},
          {23'b0, q[i].st, q[i].rd, q[i].wr, q[i].as, q[i].il, q[i].pw, q[i].rc, 1'b1});
      chk("instr_count", instr_count, model_count);
      @(negedge clk);
      if (q[i].st == 3'd2) model_count++;
    end
  endtask

  initial begin
    reset = 1'b0; waitrequest = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    md_start = 1'b0; md_done = 1'b0; halt_req = 1'b0;
    #2;
    chk("reset_outputs", {25'b0, state, read, write, addr_sel, ir_load},
        {25'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("reset_enables", {29'b0, pc_write, reg_commit, active}, 32'h1);
    chk("reset_count", instr_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Zero-wait ALU instructions: three retire in nine cycles
    for (int n = 0; n < 3; n++) run_instr(K_ALU, 0, 0, 0, 1'b0, 1'b0);
    chk("addu_x3_count", instr_count, 32'd3);
    run_instr(K_LW, 0, 2, 0, 1'b0, 1'b0);
    run_instr(K_DIV, 0, 0, 4, 1'b0, 1'b0);
    run_instr(K_BOTH, 1, 1, 0, 1'b1, 1'b0);
    run_instr(K_SW, 2, 0, 0, 1'b1, 1'b0);

    for (int n = 0; n < 40; n++)
      run_instr($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(1, 5), 1'($urandom), 1'b0);

    // Reset mid-store with the bus stalled
    waitrequest = 1'b0; mem_write = 1'b1; mem_read = 1'b0; md_start = 1'b0; halt_req = 1'b0;
    @(negedge clk);
    waitrequest = 1'b1;
    #1;
    chk("abort_pre_state", {29'b0, state}, 32'd1);
    chk("abort_pre_write", {31'b0, write}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_state", {29'b0, state}, 32'd0);
    chk("abort_strobes", {27'b0, read, write, addr_sel, ir_load, pc_write}, 32'h10);
    chk("abort_count", instr_count, 32'd0);
    model_count = 0;
    @(negedge clk);
    reset = 1'b1;

    run_instr(K_ALU, 1, 0, 0, 1'b0, 1'b0);
    run_instr(K_LW, 0, 1, 0, 1'b0, 1'b1);

    // Halted: idle regardless of inputs
    for (int n = 0; n < 20; n++) begin
      waitrequest = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
      md_start = 1'($urandom); md_done = 1'($urandom); halt_req = 1'($urandom);
      #1;
      chk("halted", {23'b0, state, read, write, addr_sel, ir_load, pc_write, reg_commit, active},
          {23'b0, 3'd4, 7'b0});
      chk("halted_count", instr_count, model_count);
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    chk("halt_reset_state", {28'b0, state, active}, {28'b0, 3'd0, 1'b1});
    chk("halt_reset_count", instr_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_count = 0;
    run_instr(K_ALU, 0, 0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_bus_sequencer.md
MIPS_BUS_SEQUENCER -- requirements
Module: mips_bus_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port waitrequest, input, 1 bit: bus stall; the current read/write is not accepted while high.
REQ-004 SHALL have ports mem_read and mem_write, input, 1 bit each: decoded MemRead/MemWrite for the instruction in IR.
REQ-005 SHALL have port md_start, input, 1 bit: the instruction in IR is MULT/MULTU/DIV/DIVU.
REQ-006 SHALL have port md_done, input, 1 bit: the HI/LO unit has finished and the result is valid.
REQ-007 SHALL have port halt_req, input, 1 bit: the next PC equals 0x00000000.
REQ-008 SHALL have port state, output, 3 bits: current state, fed to the decoder's state input.
REQ-009 SHALL have ports read and write, output, 1 bit each: bus request strobes.
REQ-010 SHALL have port addr_sel, output, 1 bit: 0 = PC drives the bus address, 1 = ALU result drives it.
REQ-011 SHALL have port ir_load, output, 1 bit: capture readdata into IR.
REQ-012 SHALL have ports pc_write and reg_commit, output, 1 bit each: PC update enable and register-file/HI/LO write enable.
REQ-013 SHALL have port active, output, 1 bit: CPU not halted.
REQ-014 SHALL have port instr_count, output, 32 bits: retired-instruction counter.

Function
REQ-015 SHALL encode states as FETCH=0, EXEC1=1, EXEC2=2, MDWAIT=3, HALTED=4; codes 5-7 SHALL go to FETCH on the next edge.
REQ-016 SHALL, in FETCH, drive read=1 and addr_sel=0.
- waitrequest=1: remain in FETCH.
- waitrequest=0: ir_load=1 that cycle; next state EXEC1.
REQ-017 SHALL, in EXEC1 with mem_write=1, drive write=1 and addr_sel=1; mem_write SHALL take priority over mem_read, with read=0.
REQ-018 SHALL, in EXEC1 with only mem_read=1, drive read=1 and addr_sel=1.
REQ-019 SHALL hold EXEC1 with strobes asserted while waitrequest=1; on the waitrequest=0 cycle it SHALL go to EXEC2.
REQ-020 SHALL, in EXEC1 with no memory operation:
- md_start=1: go to MDWAIT.
- otherwise: go to EXEC2 after one cycle.
REQ-021 SHALL ignore md_start when mem_read or mem_write is set.
REQ-022 SHALL hold MDWAIT until md_done=1, with all bus strobes low; then go to EXEC2.
REQ-023 SHALL, in EXEC2, pulse pc_write=1 and reg_commit=1 for exactly one cycle and increment instr_count by 1; instr_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 SHALL leave EXEC2 as follows:
- halt_req=1: go to HALTED.
- otherwise: go to FETCH.
REQ-025 SHALL, in HALTED, drive active=0 and all strobes/enables low, and remain there until reset.
REQ-026 SHALL drive read/write/addr_sel/ir_load/pc_write/reg_commit combinationally from the state and inputs; state and instr_count SHALL be registered.
REQ-027 SHALL keep the minimum instruction latency at 3 cycles (FETCH, EXEC1, EXEC2) with zero wait states, plus 1 cycle per waitrequest stall cycle and 1 cycle per MDWAIT cycle.

Reset
REQ-028 SHALL, on reset=0 at any time (including mid-bus-transfer or in MDWAIT), immediately force state=FETCH, instr_count=0, active=1, and write=ir_load=pc_write=reg_commit=0.
REQ-029 SHALL, while reset=0, hold read=1 and addr_sel=0 as FETCH outputs.
REQ-030 SHALL perform the first fetch on the first rising edge after reset deasserts.

Verification
REQ-031 Zero-wait ADDU sequence: waitrequest=0, no mem/md -> states 0,1,2,0 repeat; pc_write once per 3 cycles; instr_count=3 after 9 cycles.
REQ-032 LW with waitrequest high for 2 cycles in EXEC1 -> read=1, addr_sel=1 for 3 cycles; EXEC2 on cycle 5 of the instruction; instr_count+1.
REQ-033 DIV with md_done after 4 MDWAIT cycles -> no strobes in MDWAIT; reg_commit exactly once; instruction takes 7 cycles.
REQ-034 mem_read=mem_write=1 in EXEC1 -> write=1, read=0.
REQ-035 JR to 0 (halt_req=1 in EXEC2) -> HALTED; active=0; no strobes for 20 cycles; reset=0 -> state=0, instr_count=0.
REQ-036 reset=0 pulse while in EXEC1 with waitrequest=1 -> write drops in the same cycle; state=0 without a clock edge.
